// File: rtl/psum_accumulator_pkg.sv
// Shared widths for the MAC array and its downstream partial-sum accumulator,
// plus the state encoding implied by (chunk count nonzero, result pending).
package psum_accumulator_pkg;

    localparam int BW        = 8;
    localparam int BW_PSUM   = 2 * BW + 6;
    localparam int NUM_CHUNK = 8;
    localparam int CNT_BW    = $clog2(NUM_CHUNK);
    localparam int BW_ACC    = BW_PSUM + CNT_BW;

    // Encoded as {out_valid, cnt != 0}.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_ACCUM      = 2'b01,
        ST_HOLD       = 2'b10,
        ST_HOLD_ACCUM = 2'b11
    } acc_state_e;

endpackage

// File: rtl/psum_accumulator.sv
// Sums num_chunk signed MAC partial sums into one row result and holds it in a
// one-entry valid/ready output register; the next row may accumulate meanwhile.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int bw_psum   = BW_PSUM,
    parameter int num_chunk = NUM_CHUNK,
    parameter int cnt_bw    = CNT_BW,
    parameter int bw_acc    = BW_ACC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      acc_clr,
    input  logic signed [bw_psum-1:0] in_psum,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic signed [bw_acc-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    function automatic logic signed [bw_acc-1:0] sext(input logic signed [bw_psum-1:0] x);
        return {{(bw_acc - bw_psum){x[bw_psum-1]}}, x};
    endfunction

    logic        [cnt_bw-1:0] r_cnt_p0;
    logic signed [bw_acc-1:0] r_acc_p0;
    logic signed [bw_acc-1:0] r_out_data_p1;
    logic                     r_out_vld_p1;

    acc_state_e               w_state;
    logic                     w_last;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_final;
    logic signed [bw_acc-1:0] w_sum;

    assign w_state  = acc_state_e'({r_out_vld_p1, r_cnt_p0 != '0});
    assign w_last   = (r_cnt_p0 == cnt_bw'(num_chunk - 1));
    // Only the final chunk can clobber a pending result; earlier chunks keep flowing.
    assign w_stall  = (w_state == ST_HOLD_ACCUM) && w_last && !out_ready;
    assign in_ready = !acc_clr && !w_stall;
    assign w_accept = in_valid && in_ready;
    assign w_final  = w_accept && w_last;
    assign w_sum    = ((r_cnt_p0 == '0) ? '0 : r_acc_p0) + sext(in_psum);

    // Stage p0: chunk counter and running accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_p0 <= '0;
            r_acc_p0 <= '0;
        end else if (acc_clr || w_final) begin
            r_cnt_p0 <= '0;
            r_acc_p0 <= '0;
        end else if (w_accept) begin
            r_cnt_p0 <= r_cnt_p0 + cnt_bw'(1);
            r_acc_p0 <= w_sum;
        end
    end

    // Stage p1: one-entry output register; a drain and a new result may coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data_p1 <= '0;
            r_out_vld_p1  <= 1'b0;
        end else if (w_final) begin
            r_out_data_p1 <= w_sum;
            r_out_vld_p1  <= 1'b1;
        end else if (out_ready) begin
            r_out_vld_p1  <= 1'b0;
        end
    end

    assign out_data  = r_out_data_p1;
    assign out_valid = r_out_vld_p1;
    assign busy      = (r_cnt_p0 != '0);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: table of full rows plus hand-written
// backpressure, acc_clr and asynchronous-reset sequences.
module tb_psum_accumulator;

    localparam int BWP = 22;
    localparam int BWA = 25;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  acc_clr;
    logic signed [BWP-1:0] in_psum;
    logic                  in_valid;
    logic                  in_ready;
    logic signed [BWA-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    int n_cmp = 0;
    int n_err = 0;

    psum_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .acc_clr   (acc_clr),
        .in_psum   (in_psum),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BWP-1:0] psum;
        logic           gap;
        logic [BWA-1:0] exp;
    } row_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called shortly after a rising edge; returns #1 after the last accepting edge.
    task automatic feed(input logic [BWP-1:0] p, input int n, input logic gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_psum  = p;
            @(negedge clk);
            chk("in_ready_feed", {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            if (gap && i < n - 1) begin
                in_valid = 1'b0;
                in_psum  = '1;
                @(posedge clk);
                #1;
                chk("busy_gap_idle", {31'b0, busy}, 32'd1);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        row_vec_t tbl[5];
        tbl[0] = '{psum: 22'd100,     gap: 1'b0, exp: 25'd800};
        tbl[1] = '{psum: 22'h3FFFFF,  gap: 1'b0, exp: 25'h1FFFFF8};
        tbl[2] = '{psum: 22'h200000,  gap: 1'b0, exp: 25'h1000000};
        tbl[3] = '{psum: 22'h1FFFFF,  gap: 1'b0, exp: 25'h0FFFFF8};
        tbl[4] = '{psum: 22'd10,      gap: 1'b1, exp: 25'd80};

        reset     = 1'b1;
        acc_clr   = 1'b0;
        in_psum   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_out_data", {7'b0, out_data}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Full rows from the table, each drained immediately.
        for (int r = 0; r < 5; r++) begin
            feed(tbl[r].psum, 1, 1'b0);
            chk("row_busy_mid", {31'b0, busy}, 32'd1);
            chk("row_no_valid_mid", {31'b0, out_valid}, 32'd0);
            feed(tbl[r].psum, 7, tbl[r].gap);
            chk("row_out_valid", {31'b0, out_valid}, 32'd1);
            chk("row_out_data", {7'b0, out_data}, {7'b0, tbl[r].exp});
            chk("row_busy_end", {31'b0, busy}, 32'd0);
            @(posedge clk);
            #1;
            chk("row_drained", {31'b0, out_valid}, 32'd0);
            chk("row_data_held", {7'b0, out_data}, {7'b0, tbl[r].exp});
        end

        // Backpressure: result pending, next row stalls only on its final chunk.
        out_ready = 1'b0;
        feed(22'd7, 8, 1'b0);
        chk("bp_first_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_first_data", {7'b0, out_data}, 32'd56);
        feed(22'd1, 7, 1'b0);
        in_valid = 1'b1;
        in_psum  = 22'd1;
        #1;
        chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_data", {7'b0, out_data}, 32'd56);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_still_stalled", {31'b0, in_ready}, 32'd0);
        chk("bp_still_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_still_data", {7'b0, out_data}, 32'd56);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_swap_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_swap_data", {7'b0, out_data}, 32'd8);
        chk("bp_swap_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("bp_drained", {31'b0, out_valid}, 32'd0);

        // acc_clr mid-row: offered psum is refused, partial sum discarded.
        feed(22'd50, 3, 1'b0);
        acc_clr  = 1'b1;
        in_valid = 1'b1;
        in_psum  = 22'd999;
        #1;
        chk("clr_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        acc_clr  = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_no_valid", {31'b0, out_valid}, 32'd0);
        feed(22'd2, 8, 1'b0);
        chk("clr_row_valid", {31'b0, out_valid}, 32'd1);
        chk("clr_row_data", {7'b0, out_data}, 32'd16);
        @(posedge clk);
        #1;

        // Asynchronous reset between edges with a pending result and a partial row.
        out_ready = 1'b0;
        feed(22'd4, 8, 1'b0);
        feed(22'd1, 5, 1'b0);
        chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        chk("ar_pre_data", {7'b0, out_data}, 32'd32);
        chk("ar_pre_busy", {31'b0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_busy", {31'b0, busy}, 32'd0);
        chk("ar_data", {7'b0, out_data}, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        feed(22'd3, 8, 1'b0);
        chk("ar_row_valid", {31'b0, out_valid}, 32'd1);
        chk("ar_row_data", {7'b0, out_data}, 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
